seq_streamer: RTL and testbench

SEQ_STREAMER -- requirements
Module: seq_streamer

---
 rtl/seq_streamer.sv | 177 +++++++++++++++++
 tb/tb_seq_streamer.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_streamer.sv
// Streams 2-bit symbols, LSB-first, out of a packed-sequence memory.
// One word of prefetch buffering keeps sym_valid continuous across word boundaries.
module seq_streamer #(
    parameter int unsigned WORD_LEN = 32,
    parameter int unsigned ADDR_LEN = 6,
    parameter int unsigned LEN_W    = 12
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                start,
    input  logic [LEN_W-1:0]    seq_len,
    output logic                mem_rd,
    output logic [ADDR_LEN-1:0] mem_addr,
    input  logic [WORD_LEN-1:0] mem_rdata,
    output logic [1:0]          symbol,
    output logic                sym_valid,
    input  logic                sym_ready,
    output logic                BC_mode,
    output logic                busy,
    output logic                done
);

    localparam int unsigned SPW  = WORD_LEN / 2;
    localparam int unsigned WC_W = $clog2(SPW + 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        STREAM,
        FINISH
    } state_t;

    state_t                state_q, state_d;
    logic [LEN_W-1:0]      cnt_q, cnt_d;        // symbols still to transfer
    logic [LEN_W-1:0]      unf_q, unf_d;        // symbols whose word is not yet read
    logic [WORD_LEN-1:0]   shift_q, shift_d;
    logic [WC_W-1:0]       wcnt_q, wcnt_d;      // unconsumed symbols in shift_q
    logic [ADDR_LEN-1:0]   addr_q, addr_d;
    logic [WORD_LEN-1:0]   pf_q, pf_d;
    logic                  pf_valid_q, pf_valid_d;
    logic                  rd_pend_q, rd_pend_d;
    logic                  xfer;

    // Symbols a freshly loaded word contributes, capped by what is left of the sequence.
    function automatic logic [WC_W-1:0] fill_cnt(input logic [LEN_W-1:0] rem);
        if (32'(rem) >= SPW) fill_cnt = WC_W'(SPW);
        else                 fill_cnt = WC_W'(rem);
    endfunction

    function automatic logic [LEN_W-1:0] unf_next(input logic [LEN_W-1:0] rem);
        if (32'(rem) > SPW) unf_next = rem - LEN_W'(SPW);
        else                unf_next = '0;
    endfunction

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            unf_q      <= '0;
            shift_q    <= '0;
            wcnt_q     <= '0;
            addr_q     <= '0;
            pf_q       <= '0;
            pf_valid_q <= 1'b0;
            rd_pend_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            unf_q      <= unf_d;
            shift_q    <= shift_d;
            wcnt_q     <= wcnt_d;
            addr_q     <= addr_d;
            pf_q       <= pf_d;
            pf_valid_q <= pf_valid_d;
            rd_pend_q  <= rd_pend_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        unf_d      = unf_q;
        shift_d    = shift_q;
        wcnt_d     = wcnt_q;
        addr_d     = addr_q;
        pf_d       = pf_q;
        pf_valid_d = pf_valid_q;
        rd_pend_d  = rd_pend_q;
        mem_rd     = 1'b0;
        mem_addr   = addr_q;
        sym_valid  = 1'b0;
        done       = 1'b0;
        xfer       = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (seq_len != '0) begin
                        cnt_d      = seq_len;
                        unf_d      = seq_len;
                        addr_d     = '0;
                        wcnt_d     = '0;
                        pf_valid_d = 1'b0;
                        rd_pend_d  = 1'b0;
                        state_d    = FETCH;
                    end else begin
                        state_d = FINISH;
                    end
                end
            end

            FETCH: begin
                mem_rd  = 1'b1;
                unf_d   = unf_next(unf_q);
                state_d = WAIT;
            end

            WAIT: begin
                shift_d = mem_rdata;
                wcnt_d  = fill_cnt(cnt_q);
                addr_d  = addr_q + ADDR_LEN'(1);
                state_d = STREAM;
            end

            STREAM: begin
                sym_valid = (wcnt_q != '0);
                xfer      = sym_valid && sym_ready;

                // A read is only issued into an empty buffer, so capture never collides with a drain.
                if (!pf_valid_q && !rd_pend_q && unf_q != '0) begin
                    mem_rd    = 1'b1;
                    rd_pend_d = 1'b1;
                    addr_d    = addr_q + ADDR_LEN'(1);
                    unf_d     = unf_next(unf_q);
                end
                if (rd_pend_q) begin
                    pf_d       = mem_rdata;
                    pf_valid_d = 1'b1;
                    rd_pend_d  = 1'b0;
                end

                if (xfer) begin
                    cnt_d   = cnt_q - LEN_W'(1);
                    shift_d = shift_q >> 2;
                    wcnt_d  = wcnt_q - WC_W'(1);
                    if (cnt_q == LEN_W'(1)) begin
                        state_d = FINISH;
                    end else if (wcnt_q == WC_W'(1) && pf_valid_q) begin
                        shift_d    = pf_q;
                        wcnt_d     = fill_cnt(cnt_q - LEN_W'(1));
                        pf_valid_d = 1'b0;
                    end
                end else if (wcnt_q == '0 && pf_valid_q) begin
                    shift_d    = pf_q;
                    wcnt_d     = fill_cnt(cnt_q);
                    pf_valid_d = 1'b0;
                end
            end

            FINISH: begin
                done       = 1'b1;
                wcnt_d     = '0;
                pf_valid_d = 1'b0;
                rd_pend_d  = 1'b0;
                state_d    = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    assign symbol  = sym_valid ? shift_q[1:0] : 2'b00;
    assign busy    = (state_q != IDLE);
    assign BC_mode = (state_q == FETCH) || (state_q == WAIT) || (state_q == STREAM);

endmodule

// File: tb/tb_seq_streamer.sv
// Directed bench for seq_streamer: memory model, symbol scoreboard and read-address log.
// A second instance with a 2-bit address checks address wrap.
module tb_seq_streamer;

    logic        CLK = 1'b0;
    logic        RST;
    logic        start, start_b;
    logic [11:0] seq_len, seq_len_b;
    logic        mem_rd, mem_rd_b;
    logic [5:0]  mem_addr;
    logic [1:0]  mem_addr_b;
    logic [31:0] mem_rdata, mem_rdata_b;
    logic [1:0]  symbol, symbol_b;
    logic        sym_valid, sym_valid_b;
    logic        sym_ready, sym_ready_b;
    logic        BC_mode, BC_mode_b;
    logic        busy, busy_b;
    logic        done, done_b;

    always #5 CLK = ~CLK;

    seq_streamer #(.WORD_LEN(32), .ADDR_LEN(6), .LEN_W(12)) dut (
        .CLK(CLK), .RST(RST), .start(start), .seq_len(seq_len),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .symbol(symbol), .sym_valid(sym_valid), .sym_ready(sym_ready),
        .BC_mode(BC_mode), .busy(busy), .done(done)
    );

    seq_streamer #(.WORD_LEN(32), .ADDR_LEN(2), .LEN_W(12)) dut_b (
        .CLK(CLK), .RST(RST), .start(start_b), .seq_len(seq_len_b),
        .mem_rd(mem_rd_b), .mem_addr(mem_addr_b), .mem_rdata(mem_rdata_b),
        .symbol(symbol_b), .sym_valid(sym_valid_b), .sym_ready(sym_ready_b),
        .BC_mode(BC_mode_b), .busy(busy_b), .done(done_b)
    );

    logic [31:0] mem_a [0:63];
    logic [31:0] mem_b [0:3];

    // Read data is only defined in the cycle right after the strobe.
    always @(posedge CLK) begin
        mem_rdata   <= mem_rd   ? mem_a[mem_addr]   : 32'hxxxx_xxxx;
        mem_rdata_b <= mem_rd_b ? mem_b[mem_addr_b] : 32'hxxxx_xxxx;
    end

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_cyc = 0;
    int done_cnt = 0, done_cyc = 0, valid_cnt = 0, rises = 0, rise_cyc = 0, xfers = 0;
    int b_done_cnt = 0;
    logic [1:0] exp_q[$];
    logic [1:0] exp_b_q[$];
    logic [5:0] rd_q[$];
    logic [1:0] rd_b_q[$];
    logic       prev_valid = 1'b0;
    logic       prev_hold = 1'b0;
    logic [1:0] prev_sym = 2'b00;

    always @(posedge CLK) cyc++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Output monitor: scoreboard pops on each transfer, protocol rules every cycle.
    always @(negedge CLK) begin
        if (!RST) begin
            if (!sym_valid) chk("sym_zero_when_invalid", 32'(symbol), 32'd0);
            if (prev_hold) begin
                chk("hold_valid", 32'(sym_valid), 32'd1);
                chk("hold_symbol", 32'(symbol), 32'(prev_sym));
            end
            if (!busy) chk("bc_when_idle", 32'(BC_mode), 32'd0);
            if (sym_valid) begin
                valid_cnt++;
                if (!prev_valid) begin
                    rises++;
                    rise_cyc = cyc;
                end
            end
            if (sym_valid && sym_ready) begin
                xfers++;
                if (exp_q.size() == 0) chk("extra_symbol", 32'(symbol), 32'hdead);
                else chk("symbol", 32'(symbol), 32'(exp_q.pop_front()));
            end
            if (mem_rd) rd_q.push_back(mem_addr);
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                chk("bc_at_done", 32'(BC_mode), 32'd0);
                chk("busy_at_done", 32'(busy), 32'd1);
                chk("valid_at_done", 32'(sym_valid), 32'd0);
            end
            prev_valid = sym_valid;
            prev_hold  = sym_valid && !sym_ready;
            prev_sym   = symbol;

            if (sym_valid_b && sym_ready_b) begin
                if (exp_b_q.size() == 0) chk("b_extra_symbol", 32'(symbol_b), 32'hdead);
                else chk("b_symbol", 32'(symbol_b), 32'(exp_b_q.pop_front()));
            end
            if (mem_rd_b) rd_b_q.push_back(mem_addr_b);
            if (done_b) b_done_cnt++;
        end else begin
            exp_q.delete();
            prev_valid = 1'b0;
            prev_hold  = 1'b0;
        end
    end

    task automatic push_word(input logic [31:0] w, input int n, input bit to_b);
        for (int i = 0; i < n; i++) begin
            logic [31:0] t;
            t = w >> (2 * i);
            if (to_b) exp_b_q.push_back(t[1:0]);
            else      exp_q.push_back(t[1:0]);
        end
    endtask

    task automatic do_start(input logic [11:0] n);
        @(posedge CLK);
        #1;
        start     = 1'b1;
        seq_len   = n;
        start_cyc = cyc;
        @(posedge CLK);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget);
        int n;
        n = 0;
        while (done_cnt < target && n < budget) begin
            @(negedge CLK);
            n++;
        end
        chk("done_within_budget", 32'(done_cnt >= target), 32'd1);
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_mem_rd"}, 32'(mem_rd), 32'd0);
        chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        chk({tag, "_symbol"}, 32'(symbol), 32'd0);
        chk({tag, "_sym_valid"}, 32'(sym_valid), 32'd0);
        chk({tag, "_bc_mode"}, 32'(BC_mode), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
    endtask

    initial begin
        int d0, r0, v0, ri0, x0, n;
        RST         = 1'b1;
        start       = 1'b0;
        start_b     = 1'b0;
        seq_len     = '0;
        seq_len_b   = '0;
        sym_ready   = 1'b1;
        sym_ready_b = 1'b1;
        for (int i = 0; i < 64; i++) mem_a[i] = 32'h0;
        mem_a[0] = 32'hE4E4E4E4;
        mem_a[1] = 32'h0000001B;
        mem_b[0] = 32'hE4E4E4E4;
        mem_b[1] = 32'h1B1B1B1B;
        mem_b[2] = 32'hAAAAAAAA;
        mem_b[3] = 32'h55555555;

        // Reset state
        repeat (2) @(negedge CLK);
        check_outputs_zero("reset_held");
        @(posedge CLK);
        #1 RST = 1'b0;
        @(negedge CLK);
        check_outputs_zero("after_release");

        // 20 symbols over two words, no bubble, two reads
        for (int k = 0; k < 4; k++) push_word(32'hE4, 4, 1'b0);
        push_word(32'h1B, 4, 1'b0);
        d0 = done_cnt; r0 = rd_q.size(); v0 = valid_cnt; ri0 = rises;
        do_start(12'd20);
        wait_done(d0 + 1, 100);
        chk("t1_reads", 32'(rd_q.size() - r0), 32'd2);
        if (rd_q.size() - r0 >= 2) begin
            chk("t1_addr0", 32'(rd_q[r0]), 32'd0);
            chk("t1_addr1", 32'(rd_q[r0 + 1]), 32'd1);
        end
        chk("t1_valid_cycles", 32'(valid_cnt - v0), 32'd20);
        chk("t1_valid_rises", 32'(rises - ri0), 32'd1);
        chk("t1_first_latency", 32'(rise_cyc - start_cyc), 32'd3);
        chk("t1_done_latency", 32'(done_cyc - start_cyc), 32'd23);
        chk("t1_sb_empty", 32'(exp_q.size()), 32'd0);
        repeat (3) @(negedge CLK);
        chk("t1_single_done", 32'(done_cnt - d0), 32'd1);
        chk("t1_idle_busy", 32'(busy), 32'd0);

        // Zero-length request
        d0 = done_cnt; r0 = rd_q.size(); v0 = valid_cnt;
        do_start(12'd0);
        wait_done(d0 + 1, 20);
        chk("t2_done_latency", 32'(done_cyc - start_cyc), 32'd1);
        repeat (3) @(negedge CLK);
        chk("t2_reads", 32'(rd_q.size() - r0), 32'd0);
        chk("t2_valid_cycles", 32'(valid_cnt - v0), 32'd0);
        chk("t2_single_done", 32'(done_cnt - d0), 32'd1);

        // Backpressure: sym_ready alternates every cycle
        mem_a[0] = 32'h000003E4;
        push_word(32'h000003E4, 5, 1'b0);
        d0 = done_cnt; r0 = rd_q.size();
        do_start(12'd5);
        n = 0;
        while (done_cnt < d0 + 1 && n < 80) begin
            @(posedge CLK);
            #1 sym_ready = ~sym_ready;
            n++;
        end
        sym_ready = 1'b1;
        chk("t3_done_seen", 32'(done_cnt - d0), 32'd1);
        chk("t3_reads", 32'(rd_q.size() - r0), 32'd1);
        chk("t3_sb_empty", 32'(exp_q.size()), 32'd0);

        // Reset after 7 of 20 symbols, then restart from address 0
        mem_a[0] = 32'hE4E4E4E4;
        for (int k = 0; k < 4; k++) push_word(32'hE4, 4, 1'b0);
        push_word(32'h1B, 4, 1'b0);
        x0 = xfers;
        do_start(12'd20);
        n = 0;
        while (xfers < x0 + 7 && n < 60) begin
            @(negedge CLK);
            n++;
        end
        chk("t4_reached_7", 32'(xfers - x0), 32'd7);
        @(posedge CLK);
        #2 RST = 1'b1;
        #1 check_outputs_zero("t4_async_reset");
        @(posedge CLK);
        #1 RST = 1'b0;
        chk("t4_sb_flushed", 32'(exp_q.size()), 32'd0);
        push_word(32'hE4, 4, 1'b0);
        d0 = done_cnt; r0 = rd_q.size();
        do_start(12'd4);
        wait_done(d0 + 1, 60);
        chk("t4_reads", 32'(rd_q.size() - r0), 32'd1);
        if (rd_q.size() > r0) chk("t4_addr0", 32'(rd_q[r0]), 32'd0);
        chk("t4_sb_empty", 32'(exp_q.size()), 32'd0);

        // start while busy is ignored
        push_word(32'hE4E4E4E4, 5, 1'b0);
        d0 = done_cnt; r0 = rd_q.size();
        do_start(12'd5);
        repeat (2) @(posedge CLK);
        #1;
        start   = 1'b1;
        seq_len = 12'd3;
        @(posedge CLK);
        #1 start = 1'b0;
        wait_done(d0 + 1, 60);
        repeat (10) @(negedge CLK);
        chk("t5_single_done", 32'(done_cnt - d0), 32'd1);
        chk("t5_reads", 32'(rd_q.size() - r0), 32'd1);
        chk("t5_sb_empty", 32'(exp_q.size()), 32'd0);
        chk("t5_idle_busy", 32'(busy), 32'd0);

        // Address wrap on the 2-bit-address instance: 5 words
        push_word(mem_b[0], 16, 1'b1);
        push_word(mem_b[1], 16, 1'b1);
        push_word(mem_b[2], 16, 1'b1);
        push_word(mem_b[3], 16, 1'b1);
        push_word(mem_b[0], 16, 1'b1);
        @(posedge CLK);
        #1;
        start_b   = 1'b1;
        seq_len_b = 12'd80;
        @(posedge CLK);
        #1 start_b = 1'b0;
        n = 0;
        while (b_done_cnt < 1 && n < 200) begin
            @(negedge CLK);
            n++;
        end
        chk("t6_done", 32'(b_done_cnt), 32'd1);
        chk("t6_reads", 32'(rd_b_q.size()), 32'd5);
        if (rd_b_q.size() >= 5) begin
            for (int i = 0; i < 5; i++) chk("t6_addr_seq", 32'(rd_b_q[i]), 32'(i % 4));
        end
        chk("t6_sb_empty", 32'(exp_b_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
